sd_nios2_attempt_cpu_cpu_debug_ocimem_ctrl: RTL and testbench

//  Sequences debug-slave OCI memory commands (take_action_ocimem_a/b, take_no_action_ocimem_a + jdo)

---
 rtl/sd_nios2_attempt_cpu_cpu_debug_ocimem_ctrl_if.sv | 29 ++
 rtl/sd_nios2_attempt_cpu_cpu_debug_ocimem_ctrl.sv | 129 ++++++++++++
 tb/tb_sd_nios2_attempt_cpu_cpu_debug_ocimem_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/sd_nios2_attempt_cpu_cpu_debug_ocimem_ctrl_if.sv
// Bundle between the debug slave command pulses, the OCI debug RAM and the controller.
// Command pulses are single-cycle with no back-pressure; monitor_ready high means a command is accepted at once.
interface sd_nios2_attempt_cpu_cpu_debug_ocimem_ctrl_if #(
    parameter int ADDR_W = 8
) ();
    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic              take_no_action_ocimem_a;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wrdata;
    logic              ram_we;
    logic              ram_re;
    logic [31:0]       ram_rddata;
    logic [31:0]       MonDReg;
    logic              monitor_ready;
    logic              monitor_error;
    logic [1:0]        fsm_state;

    modport master (
        output jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a, ram_rddata,
        input  ram_addr, ram_wrdata, ram_we, ram_re, MonDReg, monitor_ready, monitor_error, fsm_state
    );

    modport slave (
        input  jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a, ram_rddata,
        output ram_addr, ram_wrdata, ram_we, ram_re, MonDReg, monitor_ready, monitor_error, fsm_state
    );
endinterface

// File: rtl/sd_nios2_attempt_cpu_cpu_debug_ocimem_ctrl.sv
// Turns debug-slave OCI memory command pulses into single-port debug RAM accesses
// with auto-increment addressing, a one-deep pending slot and read capture into MonDReg.
module sd_nios2_attempt_cpu_cpu_debug_ocimem_ctrl #(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 2
) (
    input logic clk,
    input logic reset,
    sd_nios2_attempt_cpu_cpu_debug_ocimem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, RD_WAIT = 2'd2, RD_CAP = 2'd3} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        cnt_q;
    logic              pend_vld_q;
    logic              pend_wr_q;
    logic [31:0]       pend_data_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [31:0]       ram_wrdata_q;
    logic              ram_we_q;
    logic              ram_re_q;
    logic [31:0]       mon_q;
    logic              err_q;

    logic              take_a, take_b, take_n;
    logic              cmd_vld, cmd_wr, collide, overflow, is_idle;
    logic              start_pend, start_new, start, start_wr, slot_load;
    logic [31:0]       start_data;
    logic [ADDR_W-1:0] addr_eff, addr_d;
    logic              unused_jdo_bits;

    assign unused_jdo_bits = ^{bus.jdo[35], bus.jdo[1:0]};

    always_comb begin
        take_a     = bus.take_action_ocimem_a;
        take_b     = bus.take_action_ocimem_b;
        take_n     = bus.take_no_action_ocimem_a;
        // ocimem_a wins over b, b over no_action; anything it shadows is lost
        cmd_vld    = take_a ? bus.jdo[36] : (take_b | take_n);
        cmd_wr     = !take_a && take_b;
        collide    = (take_a && (take_b || take_n)) || (take_b && take_n);
        addr_eff   = take_a ? bus.jdo[ADDR_W+1:2] : addr_q;
        is_idle    = (state_q == IDLE);
        start_pend = is_idle && pend_vld_q;
        start_new  = is_idle && !pend_vld_q && cmd_vld;
        start      = start_pend || start_new;
        start_wr   = start_pend ? pend_wr_q : cmd_wr;
        start_data = start_pend ? pend_data_q : bus.jdo[34:3];
        // the slot is free when empty, or when its occupant launches this very cycle
        slot_load  = cmd_vld && (start_pend || (!is_idle && !pend_vld_q));
        overflow   = cmd_vld && !is_idle && pend_vld_q;
        addr_d     = addr_eff + ADDR_W'(start);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            pend_vld_q   <= 1'b0;
            pend_wr_q    <= 1'b0;
            pend_data_q  <= '0;
            ram_addr_q   <= '0;
            ram_wrdata_q <= '0;
            ram_we_q     <= 1'b0;
            ram_re_q     <= 1'b0;
            mon_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            ram_we_q     <= 1'b0;
            ram_re_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wrdata_q <= '0;
            addr_q       <= addr_d;

            if (collide || overflow)
                err_q <= 1'b1;
            else if (take_a && bus.jdo[37])
                err_q <= 1'b0;

            if (slot_load) begin
                pend_vld_q  <= 1'b1;
                pend_wr_q   <= cmd_wr;
                pend_data_q <= bus.jdo[34:3];
            end else if (start_pend) begin
                pend_vld_q  <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        ram_addr_q <= addr_eff;
                        if (start_wr) begin
                            ram_we_q     <= 1'b1;
                            ram_wrdata_q <= start_data;
                            state_q      <= WR;
                        end else begin
                            ram_re_q <= 1'b1;
                            cnt_q    <= 2'(RD_LAT - 1);
                            state_q  <= RD_WAIT;
                        end
                    end
                end
                WR:      state_q <= IDLE;
                RD_WAIT: begin
                    if (cnt_q == 2'd0)
                        state_q <= RD_CAP;
                    else
                        cnt_q <= cnt_q - 2'd1;
                end
                RD_CAP: begin
                    mon_q   <= bus.ram_rddata;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ram_addr      = ram_addr_q;
    assign bus.ram_wrdata    = ram_wrdata_q;
    assign bus.ram_we        = ram_we_q;
    assign bus.ram_re        = ram_re_q;
    assign bus.MonDReg       = mon_q;
    assign bus.monitor_ready = is_idle && !pend_vld_q;
    assign bus.monitor_error = err_q;
    assign bus.fsm_state     = state_q;
endmodule

// File: tb/tb_sd_nios2_attempt_cpu_cpu_debug_ocimem_ctrl.sv
// Bench for the OCI memory controller: table of single commands, then hand-built
// sequences for latency, pending slot, overflow, collision and mid-read reset.
module tb_sd_nios2_attempt_cpu_cpu_debug_ocimem_ctrl;
    localparam int K_LOAD = 0, K_WR = 1, K_RD = 2, K_LDRD = 3;

    typedef struct {
        int          kind;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [7:0]  exp_addr;
        logic [31:0] exp_mon;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [41:0] exp_q[$];
    logic prev_we = 1'b0, prev_re = 1'b0;
    logic [31:0] mem [256];
    logic [31:0] rd_p0 = '0, rd_p1 = '0;

    sd_nios2_attempt_cpu_cpu_debug_ocimem_ctrl_if #(.ADDR_W(8)) bus ();

    sd_nios2_attempt_cpu_cpu_debug_ocimem_ctrl #(.ADDR_W(8), .RD_LAT(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // RAM model, two-cycle read pipe; idle cycles return a poison word
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wrdata;
        rd_p0 <= bus.ram_re ? mem[bus.ram_addr] : 32'h0BAD_BAD0;
        rd_p1 <= rd_p0;
    end
    assign bus.ram_rddata = rd_p1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        logic [41:0] e;
        @(posedge clk);
        #1;
        if (bus.ram_we || bus.ram_re) begin
            chk("strobe_exclusive", {bus.ram_we, bus.ram_re}, {bus.ram_we, ~bus.ram_we});
            chk("strobe_repeat", (bus.ram_we && prev_we) || (bus.ram_re && prev_re), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {bus.ram_we, bus.ram_re, bus.ram_addr}, 0);
            end else begin
                e = exp_q.pop_front();
                chk("strobe", {bus.ram_we, bus.ram_re, bus.ram_addr, bus.ram_we ? bus.ram_wrdata : 32'h0}, e);
            end
        end
        prev_we = bus.ram_we;
        prev_re = bus.ram_re;
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [31:0] d);
        exp_q.push_back({2'b10, a, d});
    endtask

    task automatic push_rd(input logic [7:0] a);
        exp_q.push_back({2'b01, a, 32'h0});
    endtask

    function automatic logic [37:0] jaddr(input logic [7:0] a, input bit rd, input bit clr);
        logic [37:0] j = '0;
        j[9:2] = a;
        j[36]  = rd;
        j[37]  = clr;
        return j;
    endfunction

    function automatic logic [37:0] jdata(input logic [31:0] d);
        logic [37:0] j = '0;
        j[34:3] = d;
        return j;
    endfunction

    task automatic drive(input bit a, input bit b, input bit n, input logic [37:0] j);
        bus.jdo                     = j;
        bus.take_action_ocimem_a    = a;
        bus.take_action_ocimem_b    = b;
        bus.take_no_action_ocimem_a = n;
        tick();
        bus.take_action_ocimem_a    = 1'b0;
        bus.take_action_ocimem_b    = 1'b0;
        bus.take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!bus.monitor_ready && n < 40) begin
            tick();
            n++;
        end
        chk("idle_timeout", bus.monitor_ready, 1);
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{K_LOAD, 8'h10, 32'h0,         8'h00, 32'h0};
        vecs[1]  = '{K_WR,   8'h00, 32'hDEADBEEF,  8'h10, 32'h0};
        vecs[2]  = '{K_WR,   8'h00, 32'h12345678,  8'h11, 32'h0};
        vecs[3]  = '{K_LDRD, 8'h10, 32'h0,         8'h10, 32'hDEADBEEF};
        vecs[4]  = '{K_RD,   8'h00, 32'h0,         8'h11, 32'h12345678};
        vecs[5]  = '{K_LOAD, 8'hFF, 32'h0,         8'h00, 32'h0};
        vecs[6]  = '{K_WR,   8'h00, 32'hA5A50001,  8'hFF, 32'h0};
        vecs[7]  = '{K_WR,   8'h00, 32'h5A5A0002,  8'h00, 32'h0};
        vecs[8]  = '{K_LOAD, 8'hFF, 32'h0,         8'h00, 32'h0};
        vecs[9]  = '{K_RD,   8'h00, 32'h0,         8'hFF, 32'hA5A50001};
        vecs[10] = '{K_RD,   8'h00, 32'h0,         8'h00, 32'h5A5A0002};

        bus.jdo = '0;
        bus.take_action_ocimem_a = 1'b0;
        bus.take_action_ocimem_b = 1'b0;
        bus.take_no_action_ocimem_a = 1'b0;

        // reset state
        tick();
        tick();
        chk("rst_outputs", {bus.ram_we, bus.ram_re, bus.ram_addr, bus.ram_wrdata, bus.MonDReg, bus.monitor_error}, 0);
        reset = 1'b0;
        tick();
        chk("rst_ready", bus.monitor_ready, 1);

        // single commands from idle, including address wrap at 0xFF
        for (int i = 0; i < 11; i++) begin
            case (vecs[i].kind)
                K_LOAD: drive(1, 0, 0, jaddr(vecs[i].addr, 0, 0));
                K_WR: begin
                    push_wr(vecs[i].exp_addr, vecs[i].data);
                    drive(0, 1, 0, jdata(vecs[i].data));
                end
                K_RD: begin
                    push_rd(vecs[i].exp_addr);
                    drive(0, 0, 1, '0);
                end
                default: begin
                    push_rd(vecs[i].exp_addr);
                    drive(1, 0, 0, jaddr(vecs[i].addr, 1, 0));
                end
            endcase
            wait_idle();
            if (vecs[i].kind == K_RD || vecs[i].kind == K_LDRD)
                chk($sformatf("vec%0d_mon", i), bus.MonDReg, vecs[i].exp_mon);
            chk($sformatf("vec%0d_err", i), bus.monitor_error, 0);
        end

        // read latency: MonDReg changes exactly three cycles after acceptance
        push_rd(8'h10);
        drive(1, 0, 0, jaddr(8'h10, 1, 0));
        tick();
        chk("lat_c1_mon", bus.MonDReg, 32'h5A5A0002);
        tick();
        chk("lat_c2_mon", bus.MonDReg, 32'h5A5A0002);
        chk("lat_c2_ready", bus.monitor_ready, 0);
        tick();
        chk("lat_c3_mon", bus.MonDReg, 32'hDEADBEEF);
        chk("lat_c3_ready", bus.monitor_ready, 1);

        // write queued behind a read goes to the incremented address
        push_rd(8'h10);
        drive(1, 0, 0, jaddr(8'h10, 1, 0));
        push_wr(8'h11, 32'hCAFEF00D);
        drive(0, 1, 0, jdata(32'hCAFEF00D));
        wait_idle();
        chk("pend_wr_mon", bus.MonDReg, 32'hDEADBEEF);
        chk("pend_wr_err", bus.monitor_error, 0);
        push_rd(8'h11);
        drive(1, 0, 0, jaddr(8'h11, 1, 0));
        wait_idle();
        chk("pend_wr_readback", bus.MonDReg, 32'hCAFEF00D);

        // three back-to-back reads: two run in order, third is lost
        push_rd(8'h10);
        drive(1, 0, 0, jaddr(8'h10, 1, 0));
        push_rd(8'h11);
        drive(0, 0, 1, '0);
        drive(0, 0, 1, '0);
        wait_idle();
        chk("ovf_err", bus.monitor_error, 1);
        chk("ovf_mon", bus.MonDReg, 32'hCAFEF00D);
        drive(1, 0, 0, jaddr(8'h00, 0, 1));
        chk("ovf_clear", bus.monitor_error, 0);

        // ocimem_a with ocimem_b: address loads, write lost
        drive(1, 1, 0, jaddr(8'h20, 0, 0));
        tick();
        chk("coll_err", bus.monitor_error, 1);
        push_wr(8'h20, 32'h00000077);
        drive(0, 1, 0, jdata(32'h00000077));
        wait_idle();
        drive(1, 0, 1, jaddr(8'h40, 0, 1));
        chk("coll_set_wins", bus.monitor_error, 1);
        drive(1, 0, 0, jaddr(8'h40, 0, 1));
        chk("coll_clear", bus.monitor_error, 0);

        // reset during RD_WAIT with error set
        drive(1, 1, 0, jaddr(8'h00, 0, 0));
        push_rd(8'h10);
        drive(1, 0, 0, jaddr(8'h10, 1, 0));
        chk("mid_state", bus.fsm_state, 2);
        reset = 1'b1;
        tick();
        chk("mid_rst_out", {bus.ram_we, bus.ram_re, bus.ram_addr, bus.ram_wrdata, bus.MonDReg, bus.monitor_error}, 0);
        chk("mid_rst_state", bus.fsm_state, 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("mid_mon_%0d", i), bus.MonDReg, 0);
        end
        chk("mid_ready", bus.monitor_ready, 1);
        push_wr(8'h00, 32'h11110000);
        drive(0, 1, 0, jdata(32'h11110000));
        wait_idle();

        chk("exp_q_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
